// File: rtl/count_ones_pkg.sv
// Shared types and helpers for the count_ones_seq block: the FSM state
// encoding and the result-width calculation used by the interface and RTL.
package count_ones_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold a popcount of a width-bit vector (0..width).
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/count_ones_seq_if.sv
// Handshake bundle for count_ones_seq.
// Both sides use strict valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both 1; a producer holds valid (and its data)
// until that edge, and ready never depends on anything but current state.
interface count_ones_seq_if #(
  parameter int WIDTH = 16
);
  import count_ones_pkg::*;

  localparam int CW = calc_cw(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] vec;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  // Producer/consumer side (testbench or upstream/downstream logic).
  modport master (
    output in_valid, vec, out_ready,
    input  in_ready, out_valid, count
  );

  // The counting block itself.
  modport slave (
    input  in_valid, vec, out_ready,
    output in_ready, out_valid, count
  );

endinterface

// File: rtl/count_ones_chunk.sv
// Combinational popcount of one STEP-bit chunk.
module count_ones_chunk #(
  parameter int STEP = 4,
  parameter int PW   = $clog2(STEP + 1)
) (
  input  logic [STEP-1:0] bits,
  output logic [PW-1:0]   ones
);

  // Sum the individual bits of the chunk.
  always_comb begin
    ones = '0;
    for (int i = 0; i < STEP; i++) begin
      ones = ones + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/count_ones_seq.sv
// Sequential population counter: accepts a WIDTH-bit vector, counts its
// 1-bits STEP bits per cycle through a right-shifting register, then holds
// the result until the consumer takes it.
// Optional macro COUNT_ONES_SKIP_ZERO_EN: leave COUNT early once the
// remaining shifted-out bits are all zero. Undefined by default.
module count_ones_seq
  import count_ones_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  count_ones_seq_if.slave        bus,
  output state_t                 state_dbg
);

  localparam int CW = calc_cw(WIDTH);
  localparam int K  = (WIDTH + STEP - 1) / STEP;
  localparam int RW = $clog2(K + 1);
  localparam int PW = $clog2(STEP + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] sr_shift;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    acc_next;
  logic [RW-1:0]    rem;
  logic [RW-1:0]    rem_next;
  logic [PW-1:0]    chunk_cnt;
  logic             last_chunk;

  // Bits above WIDTH never exist in sr, so the shift's zero fill pads the
  // final partial chunk automatically.
  assign sr_shift = sr >> STEP;

  count_ones_chunk #(
    .STEP (STEP),
    .PW   (PW)
  ) u_chunk (
    .bits (sr[STEP-1:0]),
    .ones (chunk_cnt)
  );

`ifdef COUNT_ONES_SKIP_ZERO_EN
  // Finish on the last chunk, or as soon as nothing but zeros remains.
  assign last_chunk = (rem == RW'(1)) || (sr_shift == '0);
`else
  // Finish after exactly K chunks.
  assign last_chunk = (rem == RW'(1));
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.count     = acc;
  assign state_dbg     = state;

  // Next-state and datapath update selection.
  always_comb begin
    state_next = state;
    sr_next    = sr;
    acc_next   = acc;
    rem_next   = rem;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sr_next    = bus.vec;
          acc_next   = '0;
          rem_next   = RW'(K);
          state_next = COUNT;
        end
      end
      COUNT: begin
        acc_next = acc + CW'(chunk_cnt);
        sr_next  = sr_shift;
        rem_next = rem - RW'(1);
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift register, accumulator and chunk counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      acc <= '0;
      rem <= '0;
    end else begin
      sr  <= sr_next;
      acc <= acc_next;
      rem <= rem_next;
    end
  end

endmodule
